instruction_memory: RTL and testbench
=====================================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit instruction words; power of two, 4..1024.
REQ-002 Parameter NOP, default 32'h00000013: fill word (addi x0,x0,0) for unprogrammed and invalid locations.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all writes occur on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset; reloads the default program image.
REQ-006 A  input  32  byte address for the instruction read (the PC).
REQ-007 RD  output  32  instruction word read at A.
REQ-008 ERR  output  1  high when A is misaligned or out of range.
REQ-009 WE  input  1  write enable for the programming port.
REQ-010 WA  input  32  byte address for the programming write.
REQ-011 WD  input  32  write data for the programming port.

Function
REQ-012 Storage: DEPTH words, each 32 bits; word index = A[log2(DEPTH)+1:2].
REQ-013 Read path: fully combinational; RD follows A within the same cycle, with no clock latency.
REQ-014 Valid read: when A[1:0]==0 and A < 4*DEPTH, RD = mem[index] and ERR = 0.
REQ-015 Misaligned read: when A[1:0]!=0, RD = NOP and ERR = 1.
REQ-016 Out-of-range read: when A >= 4*DEPTH, RD = NOP and ERR = 1; there is no wrap-around.
REQ-017 Write: on a rising clk edge with WE=1, rst=0, WA[1:0]==0 and WA < 4*DEPTH, mem[WA index] is updated to WD.
REQ-018 Invalid writes (misaligned WA or WA out of range) are silently ignored and leave memory unchanged; ERR does not reflect WA.
REQ-019 Read-during-write to the same word: RD shows the old word until the clock edge and the new word immediately after it; there is no bypass.
REQ-020 Default image, word 0..3: 32'h00500093, 32'h00300113, 32'h002081B3, 32'h00302023; all other words = NOP.

Reset
REQ-021 When rst is asserted, all words asynchronously reload the default image, without waiting for clk.
REQ-022 While rst=1, writes are blocked; if reset and a write coincide, reset wins.
REQ-023 During and after reset, RD and ERR stay combinational functions of A and the default image, so RD is valid immediately.
REQ-024 Reset asserted mid-operation discards all programmed words.

Verification
REQ-025 Pulse rst, then step A = 0x0, 0x4, 0x8, 0xC at 20 time-unit intervals -> RD = 00500093, 00300113, 002081B3, 00302023 in turn; ERR = 0 throughout.
REQ-026 A = 0x10 and A = 0xFC after reset -> RD = 00000013, ERR = 0.
REQ-027 A = 0x2 -> RD = 00000013, ERR = 1; A = 0x100 (DEPTH=64) -> RD = 00000013, ERR = 1.
REQ-028 WE=1, WA=0x8, WD=DEADBEEF with A=0x8 -> RD = 002081B3 before the edge and DEADBEEF after it; a write to WA=0x9 or WA=0x100 changes no word.
REQ-029 After writing DEADBEEF to 0x8, assert rst between clock edges -> RD at A=0x8 returns to 002081B3 immediately; a write attempted while rst=1 has no effect.

Source files
------------

// File: rtl/instruction_memory.sv
// -----------------------------------------------------------------------------
// instruction_memory
//
// Word-addressed instruction store with a combinational read port (driven by
// the PC) and a synchronous programming write port. An asynchronous reset
// reloads a small built-in default program. Every other word is filled with NOP.
//
// Parameters
//   DEPTH : number of 32-bit words (power of two, 4..1024)
//   NOP   : fill word for unprogrammed words and for invalid reads
//
// Ports
//   clk : clock; writes take effect on its rising edge
//   rst : asynchronous active-high reset; reloads the default image
//   A   : byte address of the instruction fetch
//   RD  : instruction word at A (NOP when A is invalid)
//   ERR : high when A is misaligned or beyond the last word
//   WE  : programming write enable
//   WA  : byte address of the programming write
//   WD  : programming write data
// -----------------------------------------------------------------------------
module instruction_memory #(
    parameter int          DEPTH = 64,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    output logic [31:0] RD,
    output logic        ERR,
    input  logic        WE,
    input  logic [31:0] WA,
    input  logic [31:0] WD
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    // Built-in program loaded by reset: words 0..3 hold a short sequence and
    // everything else is NOP.
    function automatic logic [31:0] default_word(input int idx);
        logic [31:0] w;
        case (idx)
            0:       w = 32'h00500093;
            1:       w = 32'h00300113;
            2:       w = 32'h002081B3;
            3:       w = 32'h00302023;
            default: w = NOP;
        endcase
        return w;
    endfunction

    // Address qualification. An address is valid only when it is word aligned
    // and every bit above the index field is zero, so out-of-range addresses
    // never wrap onto low words.
    logic          rd_aligned;
    logic          rd_in_range;
    logic          rd_valid;
    logic [AW-1:0] rd_index;

    logic          wr_aligned;
    logic          wr_in_range;
    logic          wr_valid;
    logic [AW-1:0] wr_index;

    assign rd_aligned  = (A[1:0] == 2'b00);
    assign rd_in_range = (A[31:AW+2] == '0);
    assign rd_valid    = rd_aligned && rd_in_range;
    assign rd_index    = A[AW+1:2];

    assign wr_aligned  = (WA[1:0] == 2'b00);
    assign wr_in_range = (WA[31:AW+2] == '0);
    assign wr_valid    = WE && wr_aligned && wr_in_range;
    assign wr_index    = WA[AW+1:2];

    // Storage. Reset takes priority over a coincident write. Because the reset
    // is asynchronous, the default image is visible on RD without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= default_word(i);
            end
        end else if (wr_valid) begin
            mem[wr_index] <= WD;
        end
    end

    // Combinational read with no write bypass. A write to the word being read
    // therefore appears only after the clock edge that commits it.
    always_comb begin
        RD  = NOP;
        ERR = 1'b1;
        if (rd_valid) begin
            RD  = mem[rd_index];
            ERR = 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory
//
// Directed bench for instruction_memory at DEPTH=64. Each scenario is a task
// that drives stimulus and compares RD/ERR against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_instruction_memory;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] RD;
    logic        ERR;
    logic        WE;
    logic [31:0] WA;
    logic [31:0] WD;

    int checks = 0;
    int errors = 0;

    instruction_memory #(.DEPTH(64), .NOP(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .RD  (RD),
        .ERR (ERR),
        .WE  (WE),
        .WA  (WA),
        .WD  (WD)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; WE = 1'b0; WA = '0; WD = '0; A = '0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (RD !== 32'h00500093 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_word0 RD=%h ERR=%b expected RD=00500093 ERR=0", RD, ERR);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_default_image();
        logic [31:0] exp_words [4];
        exp_words[0] = 32'h00500093;
        exp_words[1] = 32'h00300113;
        exp_words[2] = 32'h002081B3;
        exp_words[3] = 32'h00302023;
        for (int i = 0; i < 4; i++) begin
            A = 32'(i * 4);
            #1;
            checks++;
            if (RD !== exp_words[i] || ERR !== 1'b0) begin
                errors++;
                $display("FAIL default_image A=%h RD=%h ERR=%b expected RD=%h ERR=0",
                         A, RD, ERR, exp_words[i]);
            end
            #19;
        end
    endtask

    task automatic test_unprogrammed();
        logic [31:0] addrs [3];
        addrs[0] = 32'h10;
        addrs[1] = 32'h80;
        addrs[2] = 32'hFC;
        for (int i = 0; i < 3; i++) begin
            A = addrs[i];
            #1;
            checks++;
            if (RD !== NOP || ERR !== 1'b0) begin
                errors++;
                $display("FAIL unprogrammed A=%h RD=%h ERR=%b expected RD=00000013 ERR=0",
                         A, RD, ERR);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [4];
        addrs[0] = 32'h2;
        addrs[1] = 32'h1;
        addrs[2] = 32'h3;
        addrs[3] = 32'h9;
        for (int i = 0; i < 4; i++) begin
            A = addrs[i];
            #1;
            checks++;
            if (RD !== NOP || ERR !== 1'b1) begin
                errors++;
                $display("FAIL misaligned A=%h RD=%h ERR=%b expected RD=00000013 ERR=1",
                         A, RD, ERR);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [4];
        addrs[0] = 32'h100;   // first word past the end; would alias word 0
        addrs[1] = 32'h108;   // would alias word 2
        addrs[2] = 32'h1000;
        addrs[3] = 32'hFFFFFFFC;
        for (int i = 0; i < 4; i++) begin
            A = addrs[i];
            #1;
            checks++;
            if (RD !== NOP || ERR !== 1'b1) begin
                errors++;
                $display("FAIL out_of_range A=%h RD=%h ERR=%b expected RD=00000013 ERR=1",
                         A, RD, ERR);
            end
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        A = 32'h8; WE = 1'b1; WA = 32'h8; WD = 32'hDEADBEEF;
        #1;
        checks++;
        if (RD !== 32'h002081B3) begin
            errors++;
            $display("FAIL write_before_edge RD=%h expected 002081B3", RD);
        end
        @(posedge clk);
        #1;
        WE = 1'b0;
        checks++;
        if (RD !== 32'hDEADBEEF || ERR !== 1'b0) begin
            errors++;
            $display("FAIL write_after_edge RD=%h ERR=%b expected RD=DEADBEEF ERR=0", RD, ERR);
        end
        // Last word in range
        @(negedge clk);
        WE = 1'b1; WA = 32'hFC; WD = 32'h11112222; A = 32'hFC;
        @(posedge clk);
        #1;
        WE = 1'b0;
        checks++;
        if (RD !== 32'h11112222 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL write_last_word RD=%h ERR=%b expected RD=11112222 ERR=0", RD, ERR);
        end
    endtask

    task automatic test_invalid_write();
        // Misaligned WA=0x9 would hit word 2; WA=0x100 would hit word 0.
        @(negedge clk);
        WE = 1'b1; WA = 32'h9; WD = 32'h12345678; A = 32'h9;
        #1;
        checks++;
        if (ERR !== 1'b1) begin
            errors++;
            $display("FAIL err_ignores_wa ERR=%b expected 1", ERR);
        end
        @(posedge clk);
        @(negedge clk);
        WA = 32'h100; WD = 32'h87654321; A = 32'h0;
        #1;
        checks++;
        if (ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_ignores_wa_range ERR=%b expected 0", ERR);
        end
        @(posedge clk);
        @(negedge clk);
        WE = 1'b0;
        A = 32'h8;
        #1;
        checks++;
        if (RD !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL invalid_write_word2 RD=%h expected DEADBEEF", RD);
        end
        A = 32'h0;
        #1;
        checks++;
        if (RD !== 32'h00500093) begin
            errors++;
            $display("FAIL invalid_write_word0 RD=%h expected 00500093", RD);
        end
        A = 32'hC;
        #1;
        checks++;
        if (RD !== 32'h00302023) begin
            errors++;
            $display("FAIL invalid_write_word3 RD=%h expected 00302023", RD);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        WE = 1'b1; WA = 32'h10; WD = 32'hA0A0A0A0;
        @(negedge clk);
        WA = 32'h14; WD = 32'hB1B1B1B1;
        @(negedge clk);
        WA = 32'h10; WD = 32'hC2C2C2C2;   // overwrite the first one
        @(negedge clk);
        WE = 1'b0;
        A = 32'h10;
        #1;
        checks++;
        if (RD !== 32'hC2C2C2C2) begin
            errors++;
            $display("FAIL b2b_word4 RD=%h expected C2C2C2C2", RD);
        end
        A = 32'h14;
        #1;
        checks++;
        if (RD !== 32'hB1B1B1B1) begin
            errors++;
            $display("FAIL b2b_word5 RD=%h expected B1B1B1B1", RD);
        end
    endtask

    task automatic test_reset_discard();
        @(negedge clk);
        A = 32'h8;
        #2;
        rst = 1'b1;   // between edges
        #1;
        checks++;
        if (RD !== 32'h002081B3 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard_word2 RD=%h ERR=%b expected RD=002081B3 ERR=0", RD, ERR);
        end
        A = 32'h10;
        #1;
        checks++;
        if (RD !== NOP) begin
            errors++;
            $display("FAIL reset_discard_word4 RD=%h expected 00000013", RD);
        end
        A = 32'hFC;
        #1;
        checks++;
        if (RD !== NOP) begin
            errors++;
            $display("FAIL reset_discard_last RD=%h expected 00000013", RD);
        end
        // Write attempted while reset is held
        WE = 1'b1; WA = 32'h0; WD = 32'hCAFEBABE; A = 32'h0;
        @(posedge clk);
        #1;
        checks++;
        if (RD !== 32'h00500093) begin
            errors++;
            $display("FAIL write_in_reset RD=%h expected 00500093", RD);
        end
        @(negedge clk);
        WE = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (RD !== 32'h00500093) begin
            errors++;
            $display("FAIL after_reset_release RD=%h expected 00500093", RD);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_default_image();
        test_unprogrammed();
        test_misaligned();
        test_out_of_range();
        test_write();
        test_invalid_write();
        test_back_to_back();
        test_reset_discard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
